// File: rtl/stream_mux_pkg.sv
// stream_mux_pkg: mode encodings and select-width helper shared by stream_mux_rr and rr_arbiter
package stream_mux_pkg;
  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR = 1'b1;
  function automatic int sel_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin grant scanning req upward from an internal ptr; ports clk, rst_n, req, advance, grant_g -> gnt (one-hot), gnt_idx
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int N_CH = 4,
  localparam int SEL_W = sel_w(N_CH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_CH-1:0]  req,
  input  logic             advance,
  input  logic [SEL_W-1:0] grant_g,
  output logic [N_CH-1:0]  gnt,
  output logic [SEL_W-1:0] gnt_idx
);
  logic [SEL_W-1:0] ptr, j;
  logic found;
  always_comb begin
    gnt = '0;
    gnt_idx = '0;
    found = 1'b0;
    j = '0;
    for (int k = 0; k < N_CH; k++) begin
      j = SEL_W'((int'(ptr) + k) % N_CH);
      if (!found && req[j]) begin
        found = 1'b1;
        gnt_idx = j;
        gnt[j] = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr <= '0;
    else if (advance) ptr <= (grant_g == SEL_W'(N_CH - 1)) ? '0 : grant_g + 1'b1;
endmodule

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-channel valid/ready stream mux, registered output, explicit-select (mode=0) or round-robin (mode=1) grant; ports clk, rst_n, mode, sel, in_valid/in_data/in_ready, out_valid/out_data/out_ch/out_ready, plus in_last/out_last packet lock when STREAM_MUX_PKT_LOCK_EN is defined
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int WIDTH = 4,
  localparam int SEL_W = sel_w(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  input  logic [N_CH-1:0]       in_valid,
  input  logic [N_CH*WIDTH-1:0] in_data,
  output logic [N_CH-1:0]       in_ready,
`ifdef STREAM_MUX_PKT_LOCK_EN
  input  logic [N_CH-1:0]       in_last,
  output logic                  out_last,
`endif
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_ch,
  input  logic                  out_ready
);
  logic load_en, sel_ok, grant_v, acc, adv;
  logic [SEL_W-1:0] g, rr_idx;
  logic [N_CH-1:0] rr_gnt;
  assign load_en = !out_valid || out_ready;
  assign sel_ok = (int'(sel) < N_CH) && in_valid[sel];
  assign acc = grant_v && load_en;
  assign in_ready = (acc && rst_n) ? N_CH'(1) << g : '0;
  rr_arbiter #(.N_CH(N_CH)) u_arb (
    .clk(clk), .rst_n(rst_n), .req(in_valid), .advance(adv), .grant_g(g),
    .gnt(rr_gnt), .gnt_idx(rr_idx)
  );
`ifdef STREAM_MUX_PKT_LOCK_EN
  logic lock;
  logic [SEL_W-1:0] locked_ch;
  always_comb begin
    grant_v = lock ? in_valid[locked_ch] : (mode == MODE_RR ? |rr_gnt : sel_ok);
    g = lock ? locked_ch : (mode == MODE_RR ? rr_idx : sel);
  end
  assign adv = acc && mode == MODE_RR && in_last[g];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      lock <= 1'b0;
      locked_ch <= '0;
      out_last <= 1'b0;
    end else if (acc) begin
      lock <= !in_last[g];
      locked_ch <= g;
      out_last <= in_last[g];
    end
`else
  always_comb begin
    grant_v = mode == MODE_RR ? |rr_gnt : sel_ok;
    g = mode == MODE_RR ? rr_idx : sel;
  end
  assign adv = acc && mode == MODE_RR;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_ch <= '0;
    end else if (load_en) begin
      out_valid <= grant_v;
      if (grant_v) begin
        out_data <= in_data[int'(g)*WIDTH +: WIDTH];
        out_ch <= g;
      end
    end
endmodule
